// File: rtl/spi_master_ctrl.sv
// SPI initiator, mode 0 (CPOL=0, CPHA=0), MSB first, with a start/busy/done host handshake.
// sclk is derived from clk by CLK_DIV; every output is driven straight from a flop.
module spi_master_ctrl #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done,
  output logic              sclk,
  output logic              cs_n,
  output logic              mosi,
  input  logic              miso
);

  localparam int HCW = $clog2(CLK_DIV) + 1;
  localparam int BCW = $clog2(DATA_W) + 1;
  localparam logic [HCW-1:0] HcLast  = HCW'(CLK_DIV - 1);
  localparam logic [BCW-1:0] TogLast = BCW'(2 * DATA_W - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StSetup, StXfer, StHold, StGap} state_e;

  state_e            state_q, state_d;
  logic [HCW-1:0]    hcnt_q, hcnt_d;
  logic [BCW-1:0]    tog_q, tog_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              sclk_q, sclk_d;
  logic              cs_n_q, cs_n_d;
  logic              mosi_q, mosi_d;
  logic              tick;

  assign tick = (hcnt_q == HcLast);

  always_comb begin
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    tog_d     = tog_q;
    tx_d      = tx_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    sclk_d    = sclk_q;
    cs_n_d    = cs_n_q;
    mosi_d    = mosi_q;

    if (state_q != StIdle && state_q != StLoad) begin
      hcnt_d = tick ? '0 : hcnt_q + HCW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          tx_d    = tx_data;
          state_d = StLoad;
        end
      end
      StLoad: begin
        cs_n_d  = 1'b0;
        busy_d  = 1'b1;
        mosi_d  = tx_q[DATA_W-1];
        hcnt_d  = '0;
        tog_d   = '0;
        state_d = StSetup;
      end
      StSetup: begin
        if (tick) state_d = StXfer;
      end
      StXfer: begin
        if (tick) begin
          sclk_d = ~sclk_q;
          tog_d  = tog_q + BCW'(1);
          if (!sclk_q) begin
            rx_sh_d = {rx_sh_q[DATA_W-2:0], miso};
          end else if (tog_q != TogLast) begin
            tx_d   = {tx_q[DATA_W-2:0], 1'b0};
            mosi_d = tx_q[DATA_W-2];
          end
          if (tog_q == TogLast) begin
            tog_d   = '0;
            state_d = StHold;
          end
        end
      end
      StHold: begin
        if (tick) begin
          cs_n_d    = 1'b1;
          done_d    = 1'b1;
          rx_data_d = rx_sh_q;
          mosi_d    = 1'b0;
          state_d   = StGap;
        end
      end
      StGap: begin
        if (tick) begin
          busy_d = 1'b0;
          // A held start is taken as the gap expires, so back-to-back frames lose no extra cycle.
          if (start) begin
            tx_d    = tx_data;
            state_d = StLoad;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      hcnt_q    <= '0;
      tog_q     <= '0;
      tx_q      <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sclk_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      tog_q     <= tog_d;
      tx_q      <= tx_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sclk_q    <= sclk_d;
      cs_n_q    <= cs_n_d;
      mosi_q    <= mosi_d;
    end
  end

  assign rx_data = rx_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign sclk    = sclk_q;
  assign cs_n    = cs_n_q;
  assign mosi    = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: table vectors, randomized frames against a behavioural model,
// and hand-written sequences for start filtering, back-to-back frames and mid-frame reset.
module tb_spi_master_ctrl;

  localparam int DW = 8;
  localparam int CD = 2;
  localparam int LAT = 1 + (2 * DW + 2) * CD;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] tx_data;
  logic [DW-1:0] rx_data;
  logic          busy, done, sclk, cs_n, mosi, miso;

  logic          start2;
  logic [15:0]   tx2, rx2;
  logic          busy2, done2, sclk2, cs_n2, mosi2;

  logic [1:0]    mode;        // 0 loopback, 1 tied high, 2 tied low, 3 slave word
  logic [DW-1:0] slave_word;
  logic [DW-1:0] slave_sh = '0;
  logic          sclk_d1 = 1'b0;

  int cyc = 0;
  int rises = 0;
  int done_total = 0;
  int mosi_hi = 0;
  int idle_mosi_bad = 0;
  logic [DW-1:0] mosi_cap = '0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  spi_master_ctrl #(.DATA_W(DW), .CLK_DIV(CD)) dut (
    .clk(clk), .rst(rst), .start(start), .tx_data(tx_data), .rx_data(rx_data),
    .busy(busy), .done(done), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso)
  );

  spi_master_ctrl #(.DATA_W(16), .CLK_DIV(1)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .tx_data(tx2), .rx_data(rx2),
    .busy(busy2), .done(done2), .sclk(sclk2), .cs_n(cs_n2), .mosi(mosi2), .miso(mosi2)
  );

  assign miso = (mode == 2'd0) ? mosi :
                (mode == 2'd1) ? 1'b1 :
                (mode == 2'd2) ? 1'b0 : slave_sh[DW-1];

  always @(posedge clk) cyc <= cyc + 1;

  // Slave model: loads its word while deselected, presents the next bit after each sclk fall.
  always @(negedge clk) begin
    sclk_d1 <= sclk;
    if (cs_n) slave_sh <= slave_word;
    else if (sclk_d1 && !sclk) slave_sh <= {slave_sh[DW-2:0], 1'b0};
    if (done) done_total <= done_total + 1;
    if (!cs_n && mosi) mosi_hi <= mosi_hi + 1;
    if (cs_n && mosi) idle_mosi_bad <= idle_mosi_bad + 1;
  end

  always @(posedge sclk) begin
    if (!cs_n) begin
      rises    <= rises + 1;
      mosi_cap <= {mosi_cap[DW-2:0], mosi};
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_rx(input logic [1:0] md, input logic [DW-1:0] tx,
                                             input logic [DW-1:0] sw);
    case (md)
      2'd0:    return tx;
      2'd1:    return {DW{1'b1}};
      2'd2:    return '0;
      default: return sw;
    endcase
  endfunction

  task automatic run_frame(input logic [1:0] md, input logic [DW-1:0] tx, input logic [DW-1:0] sw,
                           input logic [DW-1:0] exp_rx, input bit pulses, input string nm);
    int acc, de, r0, d0, h0;
    bit got;
    @(negedge clk);
    mode = md; slave_word = sw; tx_data = tx; start = 1'b1;
    acc = cyc + 1; r0 = rises; d0 = done_total; h0 = mosi_hi;
    @(negedge clk);
    start = 1'b0;
    tx_data = DW'($urandom);
    got = 1'b0; de = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      if (done) begin
        got = 1'b1;
        de = cyc;
      end else begin
        start = pulses && (cyc == acc + 4 || cyc == acc + 19);
        @(negedge clk);
      end
    end
    start = 1'b0;
    check({nm, " done seen"}, 32'(got), 32'd1);
    check({nm, " done edge"}, 32'(de - acc), 32'(LAT));
    check({nm, " rx_data"}, 32'(rx_data), 32'(exp_rx));
    repeat (CD) @(negedge clk);
    check({nm, " busy low after gap"}, 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check({nm, " sclk rises"}, 32'(rises - r0), 32'(DW));
    check({nm, " mosi at rises"}, 32'(mosi_cap), 32'(tx));
    check({nm, " single done"}, 32'(done_total - d0), 32'd1);
    if (tx == '0) check({nm, " mosi stays low"}, 32'(mosi_hi - h0), 32'd0);
  endtask

  typedef struct {
    logic [1:0]    md;
    logic [DW-1:0] tx;
    logic [DW-1:0] sw;
    logic [DW-1:0] exp_rx;
    string         nm;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int acc, de, fe, d0;
    bit got;
    logic [1:0] md;
    logic [DW-1:0] tx, sw;

    vecs[0] = '{2'd0, 8'hA9, 8'h00, 8'hA9, "loopback A9"};
    vecs[1] = '{2'd1, 8'h00, 8'h00, 8'hFF, "miso high"};
    vecs[2] = '{2'd2, 8'h00, 8'h00, 8'h00, "miso low"};
    vecs[3] = '{2'd3, 8'hC3, 8'h5A, 8'h5A, "slave 5A"};

    rst = 1'b1; start = 1'b0; tx_data = '0; mode = 2'd0; slave_word = '0;
    start2 = 1'b0; tx2 = '0;
    #1;
    check("reset cs_n", 32'(cs_n), 32'd1);
    check("reset sclk", 32'(sclk), 32'd0);
    check("reset mosi", 32'(mosi), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset rx_data", 32'(rx_data), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 4; i++)
      run_frame(vecs[i].md, vecs[i].tx, vecs[i].sw, vecs[i].exp_rx, 1'b0, vecs[i].nm);

    run_frame(2'd0, 8'h6D, 8'h00, 8'h6D, 1'b1, "start pulses ignored");

    for (int i = 0; i < 16; i++) begin
      md = 2'($urandom_range(0, 3));
      tx = DW'($urandom);
      sw = DW'($urandom);
      run_frame(md, tx, sw, model_rx(md, tx, sw), 1'b0, "random");
    end

    // Back-to-back: start held high across the first done.
    @(negedge clk);
    mode = 2'd0; tx_data = 8'h3C; start = 1'b1;
    @(negedge clk);
    tx_data = 8'h96;
    got = 1'b0; de = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      if (done) begin got = 1'b1; de = cyc; end
      else @(negedge clk);
    end
    check("b2b first done", 32'(got), 32'd1);
    check("b2b first rx", 32'(rx_data), 32'h3C);
    got = 1'b0; fe = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (!cs_n) begin got = 1'b1; fe = cyc; end
    end
    start = 1'b0;
    check("b2b cs_n fall gap", 32'(fe - de), 32'(CD + 1));
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    check("b2b second done", 32'(got), 32'd1);
    check("b2b second rx", 32'(rx_data), 32'h96);
    repeat (4) @(negedge clk);

    // Reset at edge 15 of a frame.
    @(negedge clk);
    mode = 2'd0; tx_data = 8'hA5; start = 1'b1; acc = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < acc + 14) @(negedge clk);
    check("mid-frame cs_n low", 32'(cs_n), 32'd0);
    d0 = done_total;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort cs_n", 32'(cs_n), 32'd1);
    check("abort sclk", 32'(sclk), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    check("abort no done", 32'(done_total - d0), 32'd0);
    run_frame(2'd3, 8'h71, 8'hE4, 8'hE4, 1'b0, "after reset");

    // Wide, fast instance: DATA_W=16, CLK_DIV=1, loopback.
    @(negedge clk);
    tx2 = 16'hBEEF; start2 = 1'b1; acc = cyc + 1;
    @(negedge clk);
    start2 = 1'b0; tx2 = 16'h0000;
    got = 1'b0; de = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      if (done2) begin got = 1'b1; de = cyc; end
      else @(negedge clk);
    end
    check("w16 done seen", 32'(got), 32'd1);
    check("w16 done edge", 32'(de - acc), 32'd35);
    check("w16 rx_data", 32'(rx2), 32'hBEEF);

    check("mosi low while deselected", 32'(idle_mosi_bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
